// File: rtl/gcd_pkg.sv
// Shared types and default sizes for the GCD dispatcher and its FIFO.
// The dispatcher state enum lives here so checkers can decode it by name.
package gcd_pkg;

    localparam int GCD_WIDTH_DEF = 32;
    localparam int GCD_TAG_W_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_OUT   = 2'd3
    } disp_state_e;

endpackage

// File: rtl/gcd_fifo.sv
// Synchronous FIFO with registered occupancy count; no fall-through.
// A push while full is refused even if a pop happens in the same cycle.
module gcd_fifo #(
    parameter int WIDTH_ENTRY = 68,
    parameter int DEPTH       = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [WIDTH_ENTRY-1:0] data_i,
    output logic [WIDTH_ENTRY-1:0] data_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH_ENTRY-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [CNT_W-1:0]       r_count;
    logic                   w_push;
    logic                   w_pop;

    assign full_o  = (r_count == CNT_W'(DEPTH));
    assign empty_o = (r_count == '0);
    assign w_push  = push_i & ~full_o;
    assign w_pop   = pop_i & ~empty_o;
    assign data_o  = r_mem[r_rd_ptr];

    // Storage carries no reset; occupancy is tracked solely by r_count.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/gcd_dispatcher.sv
// Buffers operand pairs, issues them one at a time to the binary-GCD core,
// returns tagged results, and resets the core if it fails to answer in time.
module gcd_dispatcher
    import gcd_pkg::*;
#(
    parameter int WIDTH       = GCD_WIDTH_DEF,
    parameter int TAG_W       = GCD_TAG_W_DEF,
    parameter int DEPTH       = 4,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_a_i,
    input  logic [WIDTH-1:0] in_b_i,
    input  logic [TAG_W-1:0] in_tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_result_o,
    output logic [TAG_W-1:0] out_tag_o,
    output logic             out_err_o,
    output logic             gcd_rst_o,
    output logic             gcd_start_o,
    output logic [WIDTH-1:0] gcd_a_o,
    output logic [WIDTH-1:0] gcd_b_o,
    input  logic             gcd_busy_i,
    input  logic             gcd_valid_i,
    input  logic [WIDTH-1:0] gcd_result_i
);

    // Both streams are valid/ready: a transfer happens on a rising clock edge
    // where valid and ready are both high; valid never waits on ready.

    localparam int ENTRY_W = TAG_W + 2 * WIDTH;
    localparam int WD_W    = $clog2(TIMEOUT_CYC);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

    disp_state_e       r_state;
    disp_state_e       w_state_nxt;
    logic [WIDTH-1:0]  r_op_a;
    logic [WIDTH-1:0]  r_op_b;
    logic [TAG_W-1:0]  r_op_tag;
    logic [WIDTH-1:0]  r_result;
    logic              r_err;
    logic              r_gcd_rst;
    logic [WD_W-1:0]   r_wdog;

    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic              w_start;
    logic              w_capture;
    logic              w_wdog_fire;
    logic [ENTRY_W-1:0] w_head;
    logic              w_unused;

    // Busy is informational only; sequencing relies on the valid strobe.
    assign w_unused = gcd_busy_i;

    assign in_ready_o = ~w_full;
    assign w_push     = in_valid_i & in_ready_o;

    gcd_fifo #(
        .WIDTH_ENTRY(ENTRY_W),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push_i (w_push),
        .pop_i  (w_pop),
        .data_i ({in_tag_i, in_b_i, in_a_i}),
        .data_o (w_head),
        .full_o (w_full),
        .empty_o(w_empty)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_start     = 1'b0;
        w_capture   = 1'b0;
        w_wdog_fire = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_start     = 1'b1;
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                // A result arriving on the timeout cycle still counts as success.
                if (gcd_valid_i) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_OUT;
                end else if (r_wdog == WD_LAST) begin
                    w_wdog_fire = 1'b1;
                    w_state_nxt = ST_OUT;
                end
            end
            ST_OUT: begin
                if (out_ready_i) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_op_a    <= '0;
            r_op_b    <= '0;
            r_op_tag  <= '0;
            r_result  <= '0;
            r_err     <= 1'b0;
            r_gcd_rst <= 1'b0;
            r_wdog    <= '0;
        end else begin
            if (w_pop) begin
                {r_op_tag, r_op_b, r_op_a} <= w_head;
                r_wdog <= '0;
            end else if (r_state == ST_WAIT) begin
                r_wdog <= r_wdog + WD_W'(1);
            end
            if (w_capture) begin
                r_result <= gcd_result_i;
                r_err    <= 1'b0;
            end else if (w_wdog_fire) begin
                r_result <= '0;
                r_err    <= 1'b1;
            end
            r_gcd_rst <= w_wdog_fire;
        end
    end

    // Operands are held in registers so they stay put while the core samples them.
    assign gcd_start_o  = w_start;
    assign gcd_a_o      = r_op_a;
    assign gcd_b_o      = r_op_b;
    assign gcd_rst_o    = r_gcd_rst;
    assign out_valid_o  = (r_state == ST_OUT);
    assign out_result_o = r_result;
    assign out_tag_o    = r_op_tag;
    assign out_err_o    = r_err;

endmodule

// File: tb/tb_gcd_dispatcher.sv
// Directed bench for gcd_dispatcher with a behavioural GCD core alongside it.
// Expected results are hand-computed and queued at input acceptance.
module tb_gcd_dispatcher;

    localparam int W     = 32;
    localparam int TW    = 4;
    localparam int DEPTH = 4;
    localparam int TO    = 256;
    localparam int EW    = 1 + TW + W;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [W-1:0]  in_a_i;
    logic [W-1:0]  in_b_i;
    logic [TW-1:0] in_tag_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [W-1:0]  out_result_o;
    logic [TW-1:0] out_tag_o;
    logic          out_err_o;
    logic          gcd_rst_o;
    logic          gcd_start_o;
    logic [W-1:0]  gcd_a_o;
    logic [W-1:0]  gcd_b_o;
    logic          gcd_busy_i;
    logic          gcd_valid_i;
    logic [W-1:0]  gcd_result_i;

    int n_vec  = 0;
    int n_miss = 0;
    logic [EW-1:0] exp_q[$];

    always #5 clk_i = ~clk_i;

    gcd_dispatcher #(
        .WIDTH(W), .TAG_W(TW), .DEPTH(DEPTH), .TIMEOUT_CYC(TO)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_a_i(in_a_i), .in_b_i(in_b_i), .in_tag_i(in_tag_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_result_o(out_result_o), .out_tag_o(out_tag_o), .out_err_o(out_err_o),
        .gcd_rst_o(gcd_rst_o), .gcd_start_o(gcd_start_o),
        .gcd_a_o(gcd_a_o), .gcd_b_o(gcd_b_o),
        .gcd_busy_i(gcd_busy_i), .gcd_valid_i(gcd_valid_i), .gcd_result_i(gcd_result_i)
    );

    // Behavioural core: samples operands the cycle after start, answers after m_lat cycles.
    int           m_lat    = 2;
    logic         suppress = 1'b0;
    logic         stray    = 1'b0;
    logic [1:0]   m_phase;
    int           m_cnt;
    logic         m_valid;
    logic [W-1:0] m_res;

    function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] x, y, t;
        x = a;
        y = b;
        for (int i = 0; i < 100; i++) begin
            if (y != 0) begin
                t = x % y;
                x = y;
                y = t;
            end
        end
        return x;
    endfunction

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_phase <= 2'd0;
            m_cnt   <= 0;
            m_valid <= 1'b0;
            m_res   <= '0;
        end else if (gcd_rst_o) begin
            m_phase <= 2'd0;
            m_cnt   <= 0;
            m_valid <= 1'b0;
        end else begin
            m_valid <= 1'b0;
            if (m_phase == 2'd0 && gcd_start_o) begin
                m_phase <= 2'd1;
            end else if (m_phase == 2'd1) begin
                m_res   <= ref_gcd(gcd_a_o, gcd_b_o);
                m_cnt   <= m_lat;
                m_phase <= 2'd2;
            end else if (m_phase == 2'd2) begin
                if (m_cnt == 0) begin
                    if (!suppress) begin
                        m_valid <= 1'b1;
                        m_phase <= 2'd0;
                    end
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
        end
    end

    assign gcd_busy_i   = (m_phase != 2'd0);
    assign gcd_valid_i  = m_valid | stray;
    assign gcd_result_i = stray ? 32'hDEAD_BEEF : m_res;

    // Free-running monitors: start cycles, core-reset cycles, operand movement while a job is out.
    int           start_cnt = 0;
    int           rst_cnt   = 0;
    int           stab_viol = 0;
    logic         trk       = 1'b0;
    logic [W-1:0] trk_a     = '0;
    logic [W-1:0] trk_b     = '0;

    always @(negedge clk_i) begin
        if (gcd_start_o) start_cnt <= start_cnt + 1;
        if (gcd_rst_o)   rst_cnt   <= rst_cnt + 1;
        if (gcd_start_o) begin
            trk   <= 1'b1;
            trk_a <= gcd_a_o;
            trk_b <= gcd_b_o;
        end else if (trk) begin
            if (out_valid_o || !rst_ni) trk <= 1'b0;
            else if (gcd_a_o !== trk_a || gcd_b_o !== trk_b) stab_viol <= stab_viol + 1;
        end
    end

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic push_job(input logic [W-1:0] a, input logic [W-1:0] b, input logic [TW-1:0] tag,
                            input logic [W-1:0] exp_res, input logic exp_err);
        int cyc;
        in_a_i     = a;
        in_b_i     = b;
        in_tag_i   = tag;
        in_valid_i = 1'b1;
        cyc        = 0;
        while (!in_ready_o && cyc < 2000) begin
            @(negedge clk_i);
            cyc++;
        end
        check_val("push_ready", 64'(in_ready_o), 64'd1);
        if (in_ready_o) begin
            @(negedge clk_i);
            exp_q.push_back({exp_err, tag, exp_res});
        end
        in_valid_i = 1'b0;
    endtask

    task automatic pop_result(input string name);
        int cyc;
        logic [EW-1:0] e;
        out_ready_i = 1'b1;
        cyc         = 0;
        while (!out_valid_o && cyc < 2000) begin
            @(negedge clk_i);
            cyc++;
        end
        check_val({name, "_valid"}, 64'(out_valid_o), 64'd1);
        if (out_valid_o) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            check_val({name, "_result"}, 64'(out_result_o), 64'(e[W-1:0]));
            check_val({name, "_tag"},    64'(out_tag_o),    64'(e[W+TW-1:W]));
            check_val({name, "_err"},    64'(out_err_o),    64'(e[EW-1]));
            @(negedge clk_i);
        end
        out_ready_i = 1'b0;
    endtask

    // Cycles from the start pulse to out_valid_o; -1 if start never appears.
    task automatic measure_latency(output int lat);
        int cyc;
        cyc = 0;
        while (!gcd_start_o && cyc < 50) begin
            @(negedge clk_i);
            cyc++;
        end
        lat = -1;
        if (gcd_start_o) begin
            lat = 0;
            while (!out_valid_o && lat < 400) begin
                @(negedge clk_i);
                lat++;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int s, sr, lat;
        rst_ni      = 1'b0;
        in_valid_i  = 1'b0;
        in_a_i      = '0;
        in_b_i      = '0;
        in_tag_i    = '0;
        out_ready_i = 1'b0;
        repeat (3) @(negedge clk_i);

        check_val("rst_out_valid", 64'(out_valid_o), 64'd0);
        check_val("rst_result",    64'(out_result_o), 64'd0);
        check_val("rst_err",       64'(out_err_o), 64'd0);
        check_val("rst_start",     64'(gcd_start_o), 64'd0);
        check_val("rst_gcd_rst",   64'(gcd_rst_o), 64'd0);
        check_val("rst_gcd_a",     64'(gcd_a_o), 64'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);
        check_val("rst_in_ready",  64'(in_ready_o), 64'd1);

        // Stray strobe while idle must be ignored.
        stray = 1'b1;
        @(negedge clk_i);
        stray = 1'b0;
        @(negedge clk_i);
        check_val("stray_idle_valid",  64'(out_valid_o), 64'd0);
        check_val("stray_idle_result", 64'(out_result_o), 64'd0);

        // 1: single job, latency, stray strobe during OUT
        s = start_cnt;
        push_job(48, 18, 4'd3, 6, 1'b0);
        measure_latency(lat);
        check_val("t1_latency", 64'(lat), 64'd6);
        stray = 1'b1;
        @(negedge clk_i);
        stray = 1'b0;
        @(negedge clk_i);
        check_val("t1_stray_result", 64'(out_result_o), 64'd6);
        pop_result("t1");
        check_val("t1_starts", 64'(start_cnt - s), 64'd1);

        // 2: zero operands back-to-back
        s = start_cnt;
        push_job(0, 7, 4'd1, 7, 1'b0);
        push_job(9, 0, 4'd2, 9, 1'b0);
        push_job(0, 0, 4'd0, 0, 1'b0);
        repeat (3) pop_result("t2");
        check_val("t2_starts", 64'(start_cnt - s), 64'd3);

        // 3: back-pressure: one job parked in OUT plus a full FIFO
        push_job(12, 8, 4'd4, 4, 1'b0);
        push_job(35, 21, 4'd5, 7, 1'b0);
        push_job(100, 75, 4'd6, 25, 1'b0);
        push_job(17, 5, 4'd7, 1, 1'b0);
        push_job(81, 27, 4'd8, 27, 1'b0);
        repeat (20) @(negedge clk_i);
        check_val("t3_full_ready", 64'(in_ready_o), 64'd0);
        fork
            push_job(64, 48, 4'd9, 16, 1'b0);
            begin
                repeat (5) @(negedge clk_i);
                repeat (6) pop_result("t3");
            end
        join

        // 4: hung core, watchdog fires, then a normal job
        suppress = 1'b1;
        sr = rst_cnt;
        push_job(5, 10, 4'd10, 0, 1'b1);
        measure_latency(lat);
        check_val("t4_latency", 64'(lat), 64'(TO + 1));
        check_val("t4_rst_pulse", 64'(gcd_rst_o), 64'd1);
        pop_result("t4");
        check_val("t4_rst_width", 64'(rst_cnt - sr), 64'd1);
        suppress = 1'b0;
        push_job(21, 14, 4'd11, 7, 1'b0);
        pop_result("t4_after");

        // 5: wide operands, operands held through WAIT
        m_lat = 5;
        s = stab_viol;
        push_job(32'h8000_0000, 32'h4000_0000, 4'd12, 32'h4000_0000, 1'b0);
        push_job(32'hFFFF_FFFF, 32'hFFFF_FFFE, 4'd13, 1, 1'b0);
        pop_result("t5");
        pop_result("t5");
        check_val("t5_operand_stable", 64'(stab_viol - s), 64'd0);

        // 6: reset in the middle of WAIT with jobs still buffered
        m_lat = 100;
        push_job(30, 12, 4'd14, 6, 1'b0);
        push_job(8, 4, 4'd15, 4, 1'b0);
        push_job(9, 3, 4'd1, 3, 1'b0);
        repeat (10) @(negedge clk_i);
        #3 rst_ni = 1'b0;
        #1;
        check_val("t6_rst_valid", 64'(out_valid_o), 64'd0);
        check_val("t6_rst_gcd_a", 64'(gcd_a_o), 64'd0);
        check_val("t6_rst_gcd_b", 64'(gcd_b_o), 64'd0);
        check_val("t6_rst_tag",   64'(out_tag_o), 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        exp_q.delete();
        m_lat = 2;
        s = start_cnt;
        repeat (300) @(negedge clk_i);
        check_val("t6_no_out",   64'(out_valid_o), 64'd0);
        check_val("t6_no_start", 64'(start_cnt - s), 64'd0);
        check_val("t6_in_ready", 64'(in_ready_o), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
